// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset vector, canonical NOP, base opcodes and the
// {pc, instr} record passed from fetch to decode.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0080_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; serves as both the prefetch buffer and the in-flight
// PC tag queue of the fetch unit. DEPTH must be a power of two.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone says which slots hold data.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
        if (reset_n && !i_flush && i_push) assert (w_do_push);
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps up to FIFO_DEPTH words in flight or
// buffered, and hands {pc, instr} to decode; redirects flush and drop stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    input  logic        out_ready
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic          r_halted;
    logic          r_fault_pend;
    logic [31:0]   r_fault_pc;

    logic [CW-1:0] w_buf_count;
    logic [CW-1:0] w_tag_count;
    logic [CW-1:0] w_outstanding_nxt;
    logic          w_buf_full;
    logic          w_buf_empty;
    logic          w_tag_full;
    logic          w_tag_empty;
    fetch_entry_t  w_buf_head;
    fetch_entry_t  w_buf_wdata;
    logic [31:0]   w_tag_pc;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_show_fault;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_buf_pop;
    logic          w_fault_pop;

    // Credit: words in flight plus words buffered never exceed the buffer depth.
    assign w_req_valid = reset_n && !r_halted && !r_fault_pend && !redirect_valid
                       && (({1'b0, r_outstanding} + {1'b0, w_buf_count}) < CREDIT_MAX);
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_rsp_keep  = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_buf_wdata = '{pc: w_tag_pc, instr: imem_rsp_data};
    assign w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

    // A pending fault is presented only once older buffered words have drained.
    assign w_show_fault = r_fault_pend && w_buf_empty;
    assign w_out_valid  = reset_n && !redirect_valid && (w_show_fault || !w_buf_empty);
    assign w_pop        = w_out_valid && out_ready;
    assign w_buf_pop    = w_pop && !w_show_fault;
    assign w_fault_pop  = w_pop && w_show_fault;

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_rsp_keep),
        .i_data  (w_buf_wdata),
        .i_pop   (w_buf_pop),
        .i_flush (redirect_valid),
        .o_data  (w_buf_head),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (imem_rsp_valid),
        .i_flush (1'b0),
        .o_data  (w_tag_pc),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_halted      <= 1'b0;
            r_fault_pend  <= 1'b0;
            r_fault_pc    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_drop_cnt   <= w_outstanding_nxt;
                r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
                r_halted     <= 1'b0;
                r_fault_pend <= is_misaligned(redirect_pc);
                r_fault_pc   <= redirect_pc;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_fault_pop) begin
                    r_fault_pend <= 1'b0;
                    r_halted     <= 1'b1;
                end
            end
            assert (w_tag_count == r_outstanding);
            assert (!(imem_rsp_valid && w_tag_empty));
            assert (!(w_accept && w_tag_full));
            assert (!(w_buf_full && (r_outstanding != '0)));
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_out_valid;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        out_fault = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (w_out_valid) begin
            if (w_show_fault) begin
                out_fault = 1'b1;
                out_pc    = r_fault_pc;
                out_instr = NOP_INSTR;
            end else begin
                out_pc    = w_buf_head.pc;
                out_instr = w_buf_head.instr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory, stream scoreboard,
// table of redirect vectors and hand-written multi-cycle sequences.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0080_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        out_ready;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Instruction memory: fixed latency, in order, at most one response per cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc      = 0;
    int    lat      = 1;
    bit    rdy_rand = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!reset_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Stream model: after reset or an aligned redirect the core must see consecutive
    // words from that PC; a misaligned redirect yields one fault entry, then silence.
    typedef enum { M_RUN, M_FAULT, M_HALT } mode_t;
    mode_t       mode     = M_RUN;
    logic [31:0] exp_pc   = RST_PC;
    logic [31:0] req_pc   = RST_PC;
    logic [31:0] fault_pc = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr  = '0;
    int          n_accept = 0;
    int          n_pop    = 0;
    logic [31:0] acc_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset out_valid", out_valid, 1'b0);
            check("reset req_valid", imem_req_valid, 1'b0);
            mode = M_RUN; exp_pc = RST_PC; req_pc = RST_PC; prev_stall = 0;
            mq.delete();
        end else begin
            if (prev_stall && !redirect_valid) begin
                check("stall hold valid", imem_req_valid, 1'b1);
                check("stall hold addr", imem_req_addr, prev_addr);
            end
            if (mode != M_RUN) check("no fetch after fault", imem_req_valid, 1'b0);
            if (mode == M_HALT) check("out_valid while halted", out_valid, 1'b0);
            if (redirect_valid) begin
                check("redirect cycle out_valid", out_valid, 1'b0);
                check("redirect cycle req_valid", imem_req_valid, 1'b0);
            end
            if (out_valid && mode == M_RUN) begin
                check("out_pc", out_pc, exp_pc);
                check("out_instr", out_instr, mem_word(exp_pc));
                check("out_fault", out_fault, 1'b0);
                if (out_ready) exp_pc = exp_pc + 32'd4;
            end else if (out_valid && mode == M_FAULT) begin
                check("fault pc", out_pc, fault_pc);
                check("fault instr", out_instr, NOP);
                check("fault flag", out_fault, 1'b1);
                if (out_ready) mode = M_HALT;
            end
            if (out_valid && out_ready) n_pop++;
            if (imem_req_valid && imem_req_ready) begin
                check("req addr", imem_req_addr, req_pc);
                req_pc = req_pc + 32'd4;
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                acc_log.push_back(imem_req_addr);
                n_accept++;
            end
            check("in-flight bound", 32'(mq.size() <= 4), 32'd1);
            if (redirect_valid) begin
                if (redirect_pc[1:0] == 2'b00) begin
                    mode = M_RUN; exp_pc = redirect_pc; req_pc = redirect_pc;
                end else begin
                    mode = M_FAULT; fault_pc = redirect_pc;
                end
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] target;
        int          vlat;
        bit          rnd;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        bit          exp_fault;
    } vec_t;
    vec_t vecs[8];

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name, input int limit);
        int k = 0;
        while (!out_valid && k < limit) begin
            sample();
            k++;
        end
        check(name, out_valid, 1'b1);
    endtask

    initial begin
        int k;
        int a0;
        int p0;
        int nreq;

        vecs[0] = '{32'h0000_1000, 3, 0, 32'h0000_1000, mem_word(32'h0000_1000), 0};
        vecs[1] = '{32'h0000_1002, 2, 0, 32'h0000_1002, NOP, 1};
        vecs[2] = '{32'h0000_2000, 1, 0, 32'h0000_2000, mem_word(32'h0000_2000), 0};
        vecs[3] = '{32'hFFFF_FFFC, 2, 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 0};
        vecs[4] = '{32'h0000_0001, 1, 1, 32'h0000_0001, NOP, 1};
        vecs[5] = '{32'h8000_0010, 4, 1, 32'h8000_0010, mem_word(32'h8000_0010), 0};
        vecs[6] = '{32'h0000_0003, 3, 0, 32'h0000_0003, NOP, 1};
        vecs[7] = '{32'h0000_0040, 1, 0, 32'h0000_0040, mem_word(32'h0000_0040), 0};

        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset values, then release: request at once, first word two cycles later.
        repeat (3) @(posedge clk);
        sample();
        check("reset out_fault", out_fault, 1'b0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_instr", out_instr, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        sample();
        check("first req valid", imem_req_valid, 1'b1);
        check("first req addr", imem_req_addr, RST_PC);
        k = 0;
        while (!out_valid && k < 20) begin
            sample();
            k++;
        end
        check("first out_valid cycle", k, 2);
        check("first out_pc", out_pc, RST_PC);
        p0 = n_pop;
        repeat (8) sample();
        check("steady throughput", n_pop - p0, 8);

        // Backpressure with 2-cycle memory: exactly four words fetched, then one per pop.
        @(posedge clk); #1;
        out_ready = 1'b0; lat = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        a0 = n_accept;
        repeat (15) sample();
        check("backpressure accepts", n_accept - a0, 4);
        check("backpressure req_valid", imem_req_valid, 1'b0);
        check("backpressure head pc", out_pc, 32'h0000_4000);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        a0 = n_accept;
        repeat (8) sample();
        check("one fetch per pop", n_accept - a0, 1);

        // Redirect vectors applied with traffic in flight.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            lat = vecs[i].vlat; rdy_rand = vecs[i].rnd; out_ready = 1'b1;
            repeat (3) @(posedge clk);
            drive_redirect(vecs[i].target);
            wait_out_valid($sformatf("vec%0d out_valid", i), 40);
            check($sformatf("vec%0d pc", i), out_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d instr", i), out_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d fault", i), out_fault, vecs[i].exp_fault);
        end
        rdy_rand = 0;

        // Fault entry then halt until the next redirect.
        lat = 1; out_ready = 1'b1;
        drive_redirect(32'h0000_1002);
        wait_out_valid("halt fault out_valid", 20);
        check("halt fault flag", out_fault, 1'b1);
        sample();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (imem_req_valid) nreq++;
        end
        check("halt no requests", nreq, 0);
        check("halt out_valid", out_valid, 1'b0);
        drive_redirect(32'h0000_2000);
        sample();
        check("resume req valid", imem_req_valid, 1'b1);
        check("resume req addr", imem_req_addr, 32'h0000_2000);

        // Address wrap with a randomly stalling memory.
        rdy_rand = 1;
        @(posedge clk); #1;
        acc_log.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        k = 0;
        while (acc_log.size() < 2 && k < 60) begin
            sample();
            k++;
        end
        check("wrap accept count", acc_log.size(), 2);
        if (acc_log.size() >= 2) begin
            check("wrap first addr", acc_log[0], 32'hFFFF_FFFC);
            check("wrap second addr", acc_log[1], 32'h0000_0000);
        end
        rdy_rand = 0;

        // Reset for one cycle with a full buffer.
        out_ready = 1'b0; lat = 1;
        drive_redirect(32'h0000_6000);
        repeat (12) sample();
        check("full buffer out_valid", out_valid, 1'b1);
        check("full buffer req_valid", imem_req_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sample();
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset req_valid", imem_req_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        sample();
        check("restart req valid", imem_req_valid, 1'b1);
        check("restart req addr", imem_req_addr, RST_PC);

        // Random traffic against the stream model.
        p0 = n_pop;
        rdy_rand = 1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
            k = $urandom_range(0, 99);
            if (k < 6) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom & 32'h0003_FFFC) | ((k < 2) ? 32'($urandom_range(1, 3)) : 32'h0);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0; rdy_rand = 0;
        repeat (10) sample();
        check("random pops occurred", 32'(n_pop > p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
